pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage program-counter unit for the pipelined core. Owns the architectural PC register and selects each cycle between sequential increment, stall hold, halt, and redirect from a resolved branch. Branch conditions are evaluated against the EX-stage flags. Optionally, taken branches are predicted with a direct-mapped branch target buffer. Sits between the instruction-memory address port and the EX-stage branch resolution logic, and drives the pipeline flush.

## Interface
- `PC_W`, 16: PC width in bits; instructions are 2 bytes.
- `IMM_W`, 9: branch offset width, in instruction units (signed).
- `RESET_PC`, 0: PC value loaded on reset.
- `BTB_DEPTH`, 8: number of BTB entries, a power of two ≥2; used only with `PC_BTB_EN`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold PC (hazard or memory stall).
- `halt_dec` in 1: the instruction at `pc` is HLT.
- `br_valid` in 1: a branch is resolving in EX this cycle.
- `br_type` in 2: `10` = PC-relative immediate; `11` = register target; `0x` = not a branch, with `br_valid` ignored.
- `br_cond` in 3: condition code ccc.
- `br_flags` in 3: {Z, V, N} flags.
- `br_imm` in IMM_W: signed offset.
- `br_reg` in PC_W: register target.
- `br_pc` in PC_W: PC of the resolving branch.
- `br_pred` in 1: the `pred_taken` value captured when this branch was fetched.
- `pc` out PC_W: current fetch address.
- `pred_taken` out 1: the instruction at `pc` is predicted taken.
- `flush` out 1: kill all instructions younger than the branch; combinational.
- `halted` out 1: the FSM is in HALT.

## Operation
Condition `take` by ccc value:
- 000: ~Z
- 001: Z
- 010: ~Z&~N
- 011: N
- 100: Z|(~Z&~N)
- 101: Z|N
- 110: V
- 111: 1

Targets:
- `seq` = `br_pc`+2.
- `tgt` = `seq` + (sign-extended `br_imm` << 1) for type `10`; `br_reg` for type `11`.
- All arithmetic is mod 2^PC_W, and wrap-around is silent.

Mispredict (`mp`) occurs when `br_valid` & br_type[1] and any of the following holds:
- `take` differs from `br_pred`;
- `take` & `br_pred` & the predicted target differs from `tgt`. The predicted target is re-read from the BTB at `br_pc`; if that entry now misses, this counts as a mismatch.

`flush` = `mp`.

FSM states are RUN and HALT. Next-PC priority, highest first:
1. `mp`: `pc` ← (`take` ? `tgt` : `seq`), state ← RUN. This applies even from HALT, because an older branch overrides a younger HLT, and it overrides `stall`.
2. `stall`: hold `pc` and state.
3. HALT state: hold `pc`.
4. `halt_dec` in RUN: hold `pc`, state ← HALT.
5. `pred_taken`: `pc` ← BTB target.
6. Otherwise: `pc` ← `pc`+2.

Additional rules:
- HALT is exited only by `mp` or by reset.
- `halted` = (state==HALT).

## Timing
- Reset (async assert): `pc`=RESET_PC, state=RUN, `halted`=0, all BTB valid bits 0, so `pred_taken`=0. `flush` still follows its inputs.
- A redirect is visible on `pc` one edge after `mp`; the wrong-path penalty is the number of younger stages.
- `pred_taken` and `flush` are combinational from `pc` and the `br_*` inputs, with no register stage.
- Reset deasserted mid-operation: the first edge after release fetches from RESET_PC.

## Configuration
`PC_BTB_EN` defined:
- Direct-mapped BTB with BTB_DEPTH entries. Each entry holds valid, tag = `pc`[PC_W-1:log2(BTB_DEPTH)+1], and target.
- Index = `pc`[log2(BTB_DEPTH):1].
- `pred_taken` = valid & tag match.
- Write at `br_pc` on `br_valid` & type `10` & `take`.
- Invalidate on `br_valid` & `br_pred` & ~`take`.
- Register branches are never predicted.
- A write to the entry being read in the same cycle takes effect on the next cycle.

`PC_BTB_EN` undefined:
- No BTB storage.
- `pred_taken`=0 and the predicted target is unused.
- Every taken branch flushes.

## Test plan
- Reset with RESET_PC=0x0100 and 4 free-run cycles -> `pc` sequence 0x0100, 0x0102, 0x0104, 0x0106; `halted`=0.
- `br_valid`, type `10`, ccc=001, Z=1, `br_pc`=0x0010, `br_imm`=-3, `br_pred`=0 -> `flush`=1, next `pc`=0x000C. Repeat with Z=0 -> `flush`=0 and sequential fetch continues.
- `halt_dec`=1 at `pc`=0x0040 -> `halted`=1, `pc` holds 0x0040 for 10 cycles. Then `br_valid`, type `11`, ccc=111, `br_reg`=0x2000 -> `pc`=0x2000, `halted`=0.
- `stall`=1 held for 3 cycles at `pc`=0x0030 -> `pc` stays 0x0030. Then `stall`=1 together with a mispredict to 0x0050 -> `pc`=0x0050, because the redirect wins.
- Wrap: `pc`=0xFFFE, free-run -> 0x0000. Branch at 0xFFFE with imm=+1, taken -> `pc`=0x0002.
- `PC_BTB_EN`:
  - Train a taken imm branch at 0x0020 to 0x0080.
  - Refetch 0x0020 -> `pred_taken`=1, next `pc`=0x0080, with no flush on resolve.
  - Resolve the same branch not-taken -> `flush`=1, `pc`=0x0022, entry invalidated, and the next fetch of 0x0020 gives `pred_taken`=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC unit: sequential/stall/halt/redirect selection with EX-stage branch resolution.
// Define PC_BTB_EN to add a direct-mapped branch target buffer for taken-branch prediction.
module pc_fetch_ctrl #(
  parameter int              PC_W      = 16,
  parameter int              IMM_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BTB_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt_dec,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [2:0]       br_cond,
  input  logic [2:0]       br_flags,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [PC_W-1:0]  br_reg,
  input  logic [PC_W-1:0]  br_pc,
  input  logic             br_pred,
  output logic [PC_W-1:0]  pc,
  output logic             pred_taken,
  output logic             flush,
  output logic             halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, state_next;
  logic [PC_W-1:0] pc_next;

  function automatic logic cond_take(input logic [2:0] ccc, input logic [2:0] flags);
    logic z, v, n;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    case (ccc)
      3'b000:  return ~z;
      3'b001:  return z;
      3'b010:  return ~z & ~n;
      3'b011:  return n;
      3'b100:  return z | (~z & ~n);
      3'b101:  return z | n;
      3'b110:  return v;
      default: return 1'b1;
    endcase
  endfunction

  logic                    take;
  logic                    is_br;
  logic [PC_W-1:0]         seq;
  logic [PC_W-1:0]         tgt;
  logic signed [IMM_W-1:0] imm_s;
  logic signed [PC_W-1:0]  imm_ext;
  logic                    br_hit;
  logic [PC_W-1:0]         br_pred_tgt;
  logic [PC_W-1:0]         pred_tgt;
  logic                    tgt_match;
  logic                    mp;

  assign take    = cond_take(br_cond, br_flags);
  assign is_br   = br_valid & br_type[1];
  assign seq     = br_pc + PC_W'(2);
  assign imm_s   = br_imm;
  assign imm_ext = {{(PC_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
  assign tgt     = br_type[0] ? br_reg : seq + $unsigned(imm_ext <<< 1);

  // A BTB miss at br_pc counts as a predicted-target mismatch.
  assign tgt_match = br_hit & (br_pred_tgt == tgt);
  assign mp        = is_br & ((take != br_pred) | (take & br_pred & ~tgt_match));
  assign flush     = mp;

`ifdef PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 1;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [PC_W-1:0]      btb_tgt [BTB_DEPTH];
  logic [IDX_W-1:0]     fetch_idx;
  logic [IDX_W-1:0]     br_idx;
  logic                 btb_wr;
  logic                 btb_inv;

  assign fetch_idx   = pc[IDX_W:1];
  assign br_idx      = br_pc[IDX_W:1];
  assign pred_taken  = btb_valid[fetch_idx] & (btb_tag[fetch_idx] == pc[PC_W-1:IDX_W+1]);
  assign pred_tgt    = btb_tgt[fetch_idx];
  assign br_hit      = btb_valid[br_idx] & (btb_tag[br_idx] == br_pc[PC_W-1:IDX_W+1]);
  assign br_pred_tgt = btb_tgt[br_idx];
  assign btb_wr      = is_br & ~br_type[0] & take;
  assign btb_inv     = is_br & br_pred & ~take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
    end else if (btb_wr) begin
      btb_valid[br_idx] <= 1'b1;
    end else if (btb_inv) begin
      btb_valid[br_idx] <= 1'b0;
    end
  end

  // Tag/target storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[br_idx] <= br_pc[PC_W-1:IDX_W+1];
      btb_tgt[br_idx] <= tgt;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_tgt    = '0;
  assign br_hit      = 1'b0;
  assign br_pred_tgt = '0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (mp) begin
      pc_next    = take ? tgt : seq;
      state_next = RUN;
    end else if (!stall && state == RUN) begin
      if (halt_dec) begin
        state_next = HALT;
      end else if (pred_taken) begin
        pc_next = pred_tgt;
      end else begin
        pc_next = pc + PC_W'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized branches checked
// against a behavioural next-PC / BTB model.
module tb_pc_fetch_ctrl;
  localparam int          DEPTH  = 8;
  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        halt_dec = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_type = 2'b00;
  logic [2:0]  br_cond = 3'b000;
  logic [2:0]  br_flags = 3'b000;
  logic [8:0]  br_imm = 9'd0;
  logic [15:0] br_reg = 16'd0;
  logic [15:0] br_pc = 16'd0;
  logic        br_pred = 1'b0;
  logic [15:0] pc;
  logic        pred_taken;
  logic        flush;
  logic        halted;

  int n_assert = 0;
  int n_fail = 0;

  logic [15:0] m_pc;
  logic        m_halt;
  logic        m_valid [DEPTH];
  logic [15:0] m_bpc   [DEPTH];
  logic [15:0] m_btgt  [DEPTH];
  logic        obs_flush;
  logic        obs_pt;

  pc_fetch_ctrl #(.PC_W(16), .IMM_W(9), .RESET_PC(RST_PC), .BTB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_dec(halt_dec),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .br_flags(br_flags),
    .br_imm(br_imm), .br_reg(br_reg), .br_pc(br_pc), .br_pred(br_pred),
    .pc(pc), .pred_taken(pred_taken), .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic take_m(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int idx_m(input logic [15:0] a);
    return int'(a >> 1) % DEPTH;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_halt = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic clear_br();
    br_valid = 1'b0; br_type = 2'b00; br_cond = 3'b000; br_flags = 3'b000;
    br_imm = 9'd0; br_reg = 16'd0; br_pc = 16'd0; br_pred = 1'b0;
  endtask

  // One clock: check combinational outputs against the model, clock, check state.
  task automatic step(input string tag);
    logic        is_br, tk, hit, mp, pt;
    logic [15:0] sq, tg;
    int          off;
    #1;
    is_br = br_valid && br_type[1];
    tk    = take_m(br_cond, br_flags);
    sq    = br_pc + 16'd2;
    off   = $signed(br_imm);
    tg    = br_type[0] ? br_reg : 16'(int'(sq) + 2 * off);
    pt    = 1'b0;
    hit   = 1'b0;
`ifdef PC_BTB_EN
    pt  = m_valid[idx_m(m_pc)] && m_bpc[idx_m(m_pc)] == m_pc;
    hit = m_valid[idx_m(br_pc)] && m_bpc[idx_m(br_pc)] == br_pc && m_btgt[idx_m(br_pc)] == tg;
`endif
    mp = is_br && ((tk != br_pred) || (tk && br_pred && !hit));
    obs_flush = flush;
    obs_pt    = pred_taken;
    chk({tag, " flush"}, 32'(flush), 32'(mp));
    chk({tag, " pred_taken"}, 32'(pred_taken), 32'(pt));
    @(posedge clk);
    if (mp) begin
      m_pc = tk ? tg : sq;
      m_halt = 1'b0;
    end else if (!stall && !m_halt) begin
      if (halt_dec) m_halt = 1'b1;
`ifdef PC_BTB_EN
      else if (pt) m_pc = m_btgt[idx_m(m_pc)];
`endif
      else m_pc = m_pc + 16'd2;
    end
`ifdef PC_BTB_EN
    if (is_br && !br_type[0] && tk) begin
      m_valid[idx_m(br_pc)] = 1'b1;
      m_bpc[idx_m(br_pc)]   = br_pc;
      m_btgt[idx_m(br_pc)]  = tg;
    end else if (is_br && br_pred && !tk) begin
      m_valid[idx_m(br_pc)] = 1'b0;
    end
`endif
    #1;
    chk({tag, " pc"}, 32'(pc), 32'(m_pc));
    chk({tag, " halted"}, 32'(halted), 32'(m_halt));
  endtask

  task automatic redirect(input logic [15:0] a);
    br_valid = 1'b1; br_type = 2'b11; br_cond = 3'b111; br_reg = a; br_pred = 1'b0;
    br_pc = 16'h0000;
    step("redirect");
    clear_br();
    chk("redirect pc", 32'(pc), 32'(a));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", 32'(pc), 32'(RST_PC));
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    rst_n = 1'b1;

    step("free1"); chk("free1 pc", 32'(pc), 32'h0102);
    step("free2"); chk("free2 pc", 32'(pc), 32'h0104);
    step("free3"); chk("free3 pc", 32'(pc), 32'h0106);

    // Relative branch, Z=1 with ccc=001 -> taken, back by 3 instructions.
    br_valid = 1'b1; br_type = 2'b10; br_cond = 3'b001; br_flags = 3'b100;
    br_pc = 16'h0010; br_imm = 9'h1FD; br_pred = 1'b0;
    step("br_taken");
    chk("br_taken flush", 32'(obs_flush), 32'd1);
    chk("br_taken pc", 32'(pc), 32'h000C);
    br_flags = 3'b000;
    step("br_not_taken");
    chk("br_not_taken flush", 32'(obs_flush), 32'd0);
    chk("br_not_taken pc", 32'(pc), 32'h000E);
    clear_br();

    redirect(16'h0040);
    halt_dec = 1'b1;
    step("halt");
    chk("halt halted", 32'(halted), 32'd1);
    halt_dec = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("halt_hold");
      chk("halt_hold pc", 32'(pc), 32'h0040);
    end
    redirect(16'h2000);
    chk("halt_exit halted", 32'(halted), 32'd0);

    redirect(16'h0030);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall pc", 32'(pc), 32'h0030);
    end
    redirect(16'h0050);
    stall = 1'b0;

    redirect(16'hFFFE);
    step("wrap_seq");
    chk("wrap_seq pc", 32'(pc), 32'h0000);
    br_valid = 1'b1; br_type = 2'b10; br_cond = 3'b111; br_pc = 16'hFFFE;
    br_imm = 9'd1; br_pred = 1'b0;
    step("wrap_br");
    chk("wrap_br pc", 32'(pc), 32'h0002);
    clear_br();

`ifdef PC_BTB_EN
    br_valid = 1'b1; br_type = 2'b10; br_cond = 3'b111; br_pc = 16'h0020;
    br_imm = 9'd47; br_pred = 1'b0;
    step("btb_train");
    chk("btb_train pc", 32'(pc), 32'h0080);
    clear_br();
    redirect(16'h0020);
    step("btb_refetch");
    chk("btb_refetch pred", 32'(obs_pt), 32'd1);
    chk("btb_refetch pc", 32'(pc), 32'h0080);
    br_valid = 1'b1; br_type = 2'b10; br_cond = 3'b111; br_pc = 16'h0020;
    br_imm = 9'd47; br_pred = 1'b1;
    step("btb_resolve_hit");
    chk("btb_resolve_hit flush", 32'(obs_flush), 32'd0);
    br_cond = 3'b001; br_flags = 3'b000;
    step("btb_resolve_nt");
    chk("btb_resolve_nt flush", 32'(obs_flush), 32'd1);
    chk("btb_resolve_nt pc", 32'(pc), 32'h0022);
    clear_br();
    redirect(16'h0020);
    step("btb_invalidated");
    chk("btb_invalidated pred", 32'(obs_pt), 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 9) == 0);
      halt_dec = ($urandom_range(0, 19) == 0);
      br_valid = ($urandom_range(0, 2) != 0);
      br_type  = 2'($urandom_range(0, 3));
      br_cond  = 3'($urandom);
      br_flags = 3'($urandom);
      br_imm   = 9'($urandom_range(0, 63)) - 9'd32;
      br_reg   = 16'($urandom_range(0, 63) * 2);
      br_pc    = ($urandom_range(0, 1) == 1) ? m_pc : 16'($urandom_range(0, 63) * 2);
      br_pred  = 1'($urandom);
      step("rand");
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    stall = 1'b0; halt_dec = 1'b0;
    clear_br();
    #1;
    chk("midreset pc", 32'(pc), 32'(RST_PC));
    chk("midreset halted", 32'(halted), 32'd0);
    chk("midreset pred_taken", 32'(pred_taken), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_reset");
    chk("post_reset pc", 32'(pc), 32'h0102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
